// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode, control-code and FSM types shared by the ALU execute unit
package alu_pkg;

  typedef enum logic [2:0] {
    OP_R      = 3'b000,
    OP_I      = 3'b001,
    OP_LOAD   = 3'b010,
    OP_STORE  = 3'b011,
    OP_BRANCH = 3'b100,
    OP_JAL    = 3'b101
  } alu_op_t;

  // Codes 0-15 keep the legacy decoder numbering; 16-23 are the M ops in funct3 order.
  typedef enum logic [4:0] {
    CTRL_ADD, CTRL_SUB, CTRL_XOR, CTRL_OR, CTRL_AND, CTRL_SLL, CTRL_SRL, CTRL_SRA,
    CTRL_SLT, CTRL_SLTU, CTRL_BEQ, CTRL_BNE, CTRL_BLT, CTRL_BGE, CTRL_BLTU, CTRL_BGEU,
    CTRL_MUL, CTRL_MULH, CTRL_MULHSU, CTRL_MULHU, CTRL_DIV, CTRL_DIVU, CTRL_REM, CTRL_REMU
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } exec_state_t;

  localparam logic [6:0] FN7_BASE = 7'h00;
  localparam logic [6:0] FN7_ALT  = 7'h20;
  localparam logic [6:0] FN7_MEXT = 7'h01;

endpackage

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - iterative 1 bit/cycle shift-add multiplier and restoring divider
module alu_muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            abort,
  input  logic            start,
  input  logic            is_div,
  input  logic            signed_a,
  input  logic            signed_b,
  input  logic            want_hi,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] res
);

  localparam int CW = $clog2(XLEN);

  logic            busy_q;
  logic [CW-1:0]   cnt_q;
  logic            is_div_q, want_q, neg_res_q, neg_rem_q;
  logic [XLEN-1:0] hi_q, lo_q, b_q;
  logic [XLEN-1:0] hi_d, lo_d;

  logic            a_neg, b_neg;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN+1:0] diff;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0] quo_s, rem_s;

  assign a_neg = signed_a & op_a[XLEN-1];
  assign b_neg = signed_b & op_b[XLEN-1];

  // Mul: {hi,lo} is the running product with the multiplier shifting out of lo.
  // Div: {hi,lo} is {partial remainder, dividend/quotient} shifting left.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
    rem_sh  = {hi_q, lo_q[XLEN-1]};
    diff    = {1'b0, rem_sh} - {2'b00, b_q};
    if (is_div_q) begin
      if (diff[XLEN+1]) begin
        hi_d = rem_sh[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b0};
      end else begin
        hi_d = diff[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b1};
      end
    end else begin
      hi_d = mul_sum[XLEN:1];
      lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // The result is formed from the post-step values so it is ready on the last step.
  always_comb begin
    prod   = {hi_d, lo_d};
    prod_s = neg_res_q ? -prod : prod;
    quo_s  = neg_res_q ? -lo_d : lo_d;
    rem_s  = neg_rem_q ? -hi_d : hi_d;
    if (is_div_q) res = want_q ? rem_s : quo_s;
    else          res = want_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
  end

  assign busy = busy_q;
  assign done = busy_q & (cnt_q == CW'(XLEN-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      want_q    <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      b_q       <= '0;
    end else if (abort) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start) begin
      busy_q    <= 1'b1;
      cnt_q     <= '0;
      is_div_q  <= is_div;
      want_q    <= want_hi;
      neg_res_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      hi_q      <= '0;
      lo_q      <= a_neg ? -op_a : op_a;
      b_q       <= b_neg ? -op_b : op_b;
    end else if (busy_q) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + 1'b1;
      if (done) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - RV32I/M execute unit: decode, single-cycle ALU, iterative mul/div, handshake FSM
module alu_exec_unit #(
  parameter int XLEN  = 32,
  parameter int M_EXT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alu_op,
  input  logic [2:0]      fn3,
  input  logic [6:0]      fn7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            br_taken,
  output logic            illegal
);
  import alu_pkg::*;

  localparam int SHW = $clog2(XLEN);

  exec_state_t     state_q;
  logic            out_valid_q, br_q, ill_q;
  logic [XLEN-1:0] result_q;

  alu_ctrl_t       ctrl;
  logic            dec_ill;
  logic [XLEN-1:0] alu_res, sc_res;
  logic            taken, eq, lt_s, lt_u;
  logic [SHW-1:0]  shamt;
  logic            is_mulop, is_divop, want_rem, div_zero, div_ovf, iterative, accept;
  logic            mdu_busy, mdu_done;
  logic [XLEN-1:0] mdu_res;

  always_comb begin
    ctrl    = CTRL_ADD;
    dec_ill = 1'b0;
    case (alu_op)
      OP_R: begin
        if (fn7 == FN7_MEXT) begin
          if (M_EXT != 0) ctrl = alu_ctrl_t'({2'b10, fn3});
          else            dec_ill = 1'b1;
        end else if (fn7 == FN7_BASE) begin
          case (fn3)
            3'b000:  ctrl = CTRL_ADD;
            3'b001:  ctrl = CTRL_SLL;
            3'b010:  ctrl = CTRL_SLT;
            3'b011:  ctrl = CTRL_SLTU;
            3'b100:  ctrl = CTRL_XOR;
            3'b101:  ctrl = CTRL_SRL;
            3'b110:  ctrl = CTRL_OR;
            default: ctrl = CTRL_AND;
          endcase
        end else if (fn7 == FN7_ALT && fn3 == 3'b000) ctrl = CTRL_SUB;
        else if (fn7 == FN7_ALT && fn3 == 3'b101)     ctrl = CTRL_SRA;
        else dec_ill = 1'b1;
      end
      OP_I: begin
        case (fn3)
          3'b000:  ctrl = CTRL_ADD;
          3'b001:  if (fn7 == FN7_BASE) ctrl = CTRL_SLL; else dec_ill = 1'b1;
          3'b010:  ctrl = CTRL_SLT;
          3'b011:  ctrl = CTRL_SLTU;
          3'b100:  ctrl = CTRL_XOR;
          3'b101: begin
            if (fn7 == FN7_BASE)     ctrl = CTRL_SRL;
            else if (fn7 == FN7_ALT) ctrl = CTRL_SRA;
            else                     dec_ill = 1'b1;
          end
          3'b110:  ctrl = CTRL_OR;
          default: ctrl = CTRL_AND;
        endcase
      end
      OP_LOAD, OP_STORE, OP_JAL: ctrl = CTRL_ADD;
      OP_BRANCH: begin
        case (fn3)
          3'b000:  ctrl = CTRL_BEQ;
          3'b001:  ctrl = CTRL_BNE;
          3'b100:  ctrl = CTRL_BLT;
          3'b101:  ctrl = CTRL_BGE;
          3'b110:  ctrl = CTRL_BLTU;
          3'b111:  ctrl = CTRL_BGEU;
          default: dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  assign shamt = op_b[SHW-1:0];
  assign eq    = (op_a == op_b);
  assign lt_s  = ($signed(op_a) < $signed(op_b));
  assign lt_u  = (op_a < op_b);

  always_comb begin
    alu_res = '0;
    taken   = 1'b0;
    case (ctrl)
      CTRL_ADD:  alu_res = op_a + op_b;
      CTRL_SUB:  alu_res = op_a - op_b;
      CTRL_XOR:  alu_res = op_a ^ op_b;
      CTRL_OR:   alu_res = op_a | op_b;
      CTRL_AND:  alu_res = op_a & op_b;
      CTRL_SLL:  alu_res = op_a << shamt;
      CTRL_SRL:  alu_res = op_a >> shamt;
      CTRL_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
      CTRL_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
      CTRL_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
      CTRL_BEQ:  taken = eq;
      CTRL_BNE:  taken = ~eq;
      CTRL_BLT:  taken = lt_s;
      CTRL_BGE:  taken = ~lt_s;
      CTRL_BLTU: taken = lt_u;
      CTRL_BGEU: taken = ~lt_u;
      default:   alu_res = '0;
    endcase
    if (alu_op == OP_BRANCH) alu_res = {{(XLEN-1){1'b0}}, taken};
  end

  assign is_mulop = ctrl inside {CTRL_MUL, CTRL_MULH, CTRL_MULHSU, CTRL_MULHU};
  assign is_divop = ctrl inside {CTRL_DIV, CTRL_DIVU, CTRL_REM, CTRL_REMU};
  assign want_rem = ctrl inside {CTRL_REM, CTRL_REMU};
  assign div_zero = (op_b == '0);
  assign div_ovf  = (ctrl inside {CTRL_DIV, CTRL_REM}) &&
                    (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);

  // Divide-by-zero and signed overflow have fixed answers, so they skip the divider.
  always_comb begin
    sc_res = alu_res;
    if (is_divop) begin
      if (div_zero) sc_res = want_rem ? op_a : '1;
      else          sc_res = want_rem ? '0 : op_a;
    end
  end

  assign iterative = ~dec_ill & (is_mulop | (is_divop & ~div_zero & ~div_ovf));
  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign accept    = in_valid & in_ready;

  alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .abort    (flush),
    .start    (accept & iterative & ~flush),
    .is_div   (is_divop),
    .signed_a (ctrl inside {CTRL_MULH, CTRL_MULHSU, CTRL_DIV, CTRL_REM}),
    .signed_b (ctrl inside {CTRL_MULH, CTRL_DIV, CTRL_REM}),
    .want_hi  (is_divop ? want_rem : (ctrl != CTRL_MUL)),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (mdu_busy),
    .done     (mdu_done),
    .res      (mdu_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      br_q        <= 1'b0;
      ill_q       <= 1'b0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      br_q        <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (state_q == ST_DONE && out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
          if (accept) begin
            if (iterative) begin
              state_q     <= is_divop ? ST_DIV : ST_MUL;
              out_valid_q <= 1'b0;
            end else begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
              result_q    <= dec_ill ? '0 : sc_res;
              br_q        <= taken & ~dec_ill;
              ill_q       <= dec_ill;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (mdu_done) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            result_q    <= mdu_res;
            br_q        <= 1'b0;
            ill_q       <= 1'b0;
          end else if (!mdu_busy) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign br_taken  = br_q;
  assign illegal   = ill_q;

endmodule
